// File: rtl/uart_arb_pkg.sv
// rtl/uart_arb_pkg.sv - shared state encoding and width helpers for the UART transmit arbiter
package uart_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    BUSY   = 2'd2,
    GAP    = 2'd3
  } arb_state_e;

  localparam int BYTE_W = 8;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  function automatic int frame_w(input int bytes);
    return bytes * BYTE_W;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin picker: first set request at or after ptr, wrapping
module rr_pick #(
  parameter int N_REQ = 3,
  parameter int ID_W  = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic             any,
  output logic [ID_W-1:0]  winner
);

  logic [2*N_REQ-1:0] masked;

  // Lower copy masked below ptr; the upper copy supplies the wrap-around candidates.
  always_comb begin
    masked = {req, req};
    for (int j = 0; j < N_REQ; j++) begin
      if (j < int'(ptr)) masked[j] = 1'b0;
    end
    winner = '0;
    for (int j = 2*N_REQ-1; j >= 0; j--) begin
      if (masked[j]) winner = (j >= N_REQ) ? ID_W'(j - N_REQ) : ID_W'(j);
    end
  end

  assign any = |req;

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin sharing of one multi-byte UART transmitter with gap and watchdog
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter  int N_REQ          = 3,
  parameter  int BYTES          = 4,
  parameter  int GAP_CYCLES     = 16,
  parameter  int TIMEOUT_CYCLES = 2_000_000,
  localparam int ID_W           = (clog2(N_REQ) > 1) ? clog2(N_REQ) : 1,
  localparam int FRAME_W        = frame_w(BYTES)
) (
  input  logic                       sys_clk,
  input  logic                       sys_rst,
  input  logic [N_REQ-1:0]           req,
  input  logic [N_REQ*FRAME_W-1:0]   req_data,
  output logic [N_REQ-1:0]           ack,
  output logic                       busy,
  output logic [ID_W-1:0]            grant_id,
  output logic                       timeout_err,
  output logic [FRAME_W-1:0]         uart_bytes_data,
  output logic                       uart_bytes_en,
  input  logic                       uart_bytes_done
);

  localparam int GCW = (clog2(GAP_CYCLES) > 1) ? clog2(GAP_CYCLES) : 1;
  localparam int TCW = (clog2(TIMEOUT_CYCLES) > 1) ? clog2(TIMEOUT_CYCLES) : 1;

  arb_state_e         state_q, state_d;
  logic [ID_W-1:0]    ptr_q, ptr_d;
  logic [ID_W-1:0]    grant_id_q, grant_id_d;
  logic [FRAME_W-1:0] data_q, data_d;
  logic [N_REQ-1:0]   ack_q, ack_d;
  logic               err_q, err_d;
  logic [GCW-1:0]     gap_cnt_q, gap_cnt_d;
  logic [TCW-1:0]     tmo_cnt_q, tmo_cnt_d;
  logic               pick_any;
  logic [ID_W-1:0]    pick_id;

  rr_pick #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_pick (
    .req    (req),
    .ptr    (ptr_q),
    .any    (pick_any),
    .winner (pick_id)
  );

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    grant_id_d = grant_id_q;
    data_d     = data_q;
    ack_d      = '0;
    err_d      = 1'b0;
    gap_cnt_d  = gap_cnt_q;
    tmo_cnt_d  = tmo_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (pick_any) begin
          state_d    = LAUNCH;
          grant_id_d = pick_id;
          data_d     = req_data[pick_id*FRAME_W +: FRAME_W];
          ptr_d      = (pick_id == ID_W'(N_REQ-1)) ? '0 : pick_id + 1'b1;
        end
      end
      LAUNCH: begin
        state_d   = BUSY;
        tmo_cnt_d = '0;
      end
      BUSY: begin
        // A done arriving on the terminal count still completes the frame normally.
        if (uart_bytes_done || (tmo_cnt_q == TCW'(TIMEOUT_CYCLES-1))) begin
          if (uart_bytes_done) begin
            for (int i = 0; i < N_REQ; i++) ack_d[i] = (ID_W'(i) == grant_id_q);
          end else begin
            err_d = 1'b1;
          end
          state_d   = (GAP_CYCLES == 0) ? IDLE : GAP;
          gap_cnt_d = '0;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
      end
      GAP: begin
        if (gap_cnt_q == GCW'(GAP_CYCLES-1)) state_d = IDLE;
        else gap_cnt_d = gap_cnt_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      grant_id_q <= '0;
      data_q     <= '0;
      ack_q      <= '0;
      err_q      <= 1'b0;
      gap_cnt_q  <= '0;
      tmo_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      grant_id_q <= grant_id_d;
      data_q     <= data_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
      gap_cnt_q  <= gap_cnt_d;
      tmo_cnt_q  <= tmo_cnt_d;
    end
  end

  assign busy            = (state_q != IDLE);
  assign uart_bytes_en   = (state_q == LAUNCH);
  assign ack             = ack_q;
  assign timeout_err     = err_q;
  assign grant_id        = grant_id_q;
  assign uart_bytes_data = data_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - self-checking bench for uart_tx_arbiter against a round-robin reference model
module tb_uart_tx_arbiter;

  localparam int N_REQ          = 3;
  localparam int BYTES          = 4;
  localparam int GAP_CYCLES     = 4;
  localparam int TIMEOUT_CYCLES = 120;
  localparam int FW             = BYTES * 8;

  logic                  sys_clk = 1'b0;
  logic                  sys_rst = 1'b1;
  logic [N_REQ-1:0]      req = '0;
  logic [N_REQ*FW-1:0]   req_data = '0;
  logic [N_REQ-1:0]      ack;
  logic                  busy;
  logic [1:0]            grant_id;
  logic                  timeout_err;
  logic [FW-1:0]         uart_bytes_data;
  logic                  uart_bytes_en;
  logic                  uart_bytes_done = 1'b0;

  int            n_cmp = 0;
  int            n_bad = 0;
  int            m_ptr = 0;
  int            w;
  logic [FW-1:0] cap_data;

  always #5 sys_clk = ~sys_clk;

  uart_tx_arbiter #(
    .N_REQ          (N_REQ),
    .BYTES          (BYTES),
    .GAP_CYCLES     (GAP_CYCLES),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) dut (
    .sys_clk         (sys_clk),
    .sys_rst         (sys_rst),
    .req             (req),
    .req_data        (req_data),
    .ack             (ack),
    .busy            (busy),
    .grant_id        (grant_id),
    .timeout_err     (timeout_err),
    .uart_bytes_data (uart_bytes_data),
    .uart_bytes_en   (uart_bytes_en),
    .uart_bytes_done (uart_bytes_done)
  );

  task automatic tick();
    @(negedge sys_clk);
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int model_pick(input logic [N_REQ-1:0] r, input int p);
    for (int k = 0; k < N_REQ; k++) begin
      if (r[(p + k) % N_REQ]) return (p + k) % N_REQ;
    end
    return -1;
  endfunction

  task automatic randomize_frames();
    for (int i = 0; i < N_REQ; i++) req_data[i*FW +: FW] = $urandom;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ack"},   ack, 0);
    check({tag, "_busy"},  busy, 0);
    check({tag, "_grant"}, grant_id, 0);
    check({tag, "_err"},   timeout_err, 0);
    check({tag, "_data"},  uart_bytes_data, 0);
    check({tag, "_en"},    uart_bytes_en, 0);
  endtask

  // Called at a negedge while idle; returns at the first BUSY negedge.
  task automatic launch(input logic [N_REQ-1:0] r, output int win);
    win      = model_pick(r, m_ptr);
    cap_data = req_data[win*FW +: FW];
    m_ptr    = (win + 1) % N_REQ;
    req      = r;
    tick();
    check("en_pulse", uart_bytes_en, 1);
    check("grant_id", grant_id, win);
    check("frame_data", uart_bytes_data, cap_data);
    check("busy_launch", busy, 1);
    tick();
    check("en_one_cycle", uart_bytes_en, 0);
  endtask

  task automatic gap_check(input int win);
    repeat (GAP_CYCLES - 1) tick();
    check("busy_in_gap", busy, 1);
    tick();
    check("idle_after_gap", busy, 0);
    check("grant_held", grant_id, win);
    check("ack_dropped", ack, 0);
    check("err_dropped", timeout_err, 0);
  endtask

  task automatic finish_done(input int win, input int dly);
    repeat (dly) tick();
    check("data_stable", uart_bytes_data, cap_data);
    check("busy_wait", busy, 1);
    uart_bytes_done = 1'b1;
    tick();
    uart_bytes_done = 1'b0;
    check("ack_owner", ack, 64'(1) << win);
    check("no_err_on_done", timeout_err, 0);
    req[win] = 1'b0;
    gap_check(win);
  endtask

  task automatic finish_timeout(input int win);
    repeat (TIMEOUT_CYCLES - 1) tick();
    check("no_early_timeout", timeout_err, 0);
    tick();
    check("timeout_pulse", timeout_err, 1);
    check("no_ack_on_timeout", ack, 0);
    req[win] = 1'b0;
    gap_check(win);
  endtask

  initial begin
    repeat (3) tick();
    check_all_zero("reset");
    sys_rst = 1'b0;
    tick();

    // Single requester, fixed frame, long transmit.
    req_data[1*FW +: FW] = 32'h1234_5678;
    launch(3'b010, w);
    check("t1_grant", grant_id, 1);
    check("t1_data", uart_bytes_data, 32'h1234_5678);
    finish_done(w, 100);

    // All requesters held: grants rotate.
    for (int i = 0; i < 6; i++) begin
      randomize_frames();
      launch(3'b111, w);
      check("rr_order", grant_id, (i + 2) % N_REQ);
      finish_done(w, $urandom_range(0, 30));
    end

    // Frame data changes after capture must not reach the transmitter.
    randomize_frames();
    launch(3'b100, w);
    req_data[2*FW +: FW] = 32'hDEAD_BEEF;
    finish_done(w, 20);

    // Transmitter never completes.
    randomize_frames();
    launch(3'b001, w);
    finish_timeout(w);

    // Done coinciding with the terminal count, then a stray done while idle.
    randomize_frames();
    launch(3'b010, w);
    finish_done(w, TIMEOUT_CYCLES - 1);
    req = '0;
    uart_bytes_done = 1'b1;
    tick();
    uart_bytes_done = 1'b0;
    check("idle_done_ack", ack, 0);
    check("idle_done_busy", busy, 0);
    check("idle_done_en", uart_bytes_en, 0);
    check("idle_done_err", timeout_err, 0);

    // Reset in the middle of a frame, with requests pending.
    randomize_frames();
    launch(3'b010, w);
    repeat (5) tick();
    sys_rst = 1'b1;
    req     = 3'b101;
    tick();
    check_all_zero("mid_reset");
    sys_rst = 1'b0;
    m_ptr   = 0;
    randomize_frames();
    launch(3'b101, w);
    check("post_reset_ptr", grant_id, 0);
    finish_done(w, 3);
    launch(3'b100, w);
    check("pending_req2", grant_id, 2);
    finish_done(w, 7);

    // Random request patterns and completion times.
    for (int i = 0; i < 10; i++) begin
      randomize_frames();
      launch(3'($urandom_range(1, 7)), w);
      if ($urandom_range(0, 3) == 0) finish_timeout(w);
      else finish_done(w, $urandom_range(0, TIMEOUT_CYCLES - 1));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
